// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clb_cfg_pkg;

    localparam int FRAME_BYTES = 5;   // bytes per CLB frame
    localparam int SEL_BYTE    = 4;   // frame byte carrying the mode select
    localparam int LUT_BITS    = 32;  // 5-input LUT init width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } cfg_state_e;

    // CLB index width; a single CLB still needs a 1-bit counter.
    function automatic int clb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clb_cfg_shadow.sv
// Shadow bank: NUM_CLB x 5 bytes, byte-addressed writes, full parallel read-out.
// Latency: write visible on read-out one cycle after the write edge.
// Backpressure: none; every asserted wr_en is stored.
module clb_cfg_shadow
    import clb_cfg_pkg::*;
#(
    parameter int NUM_CLB   = 4,
    parameter int CLB_IDX_W = 2,
    parameter int SEL_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [CLB_IDX_W-1:0]          wr_clb,
    input  logic [2:0]                    wr_byte,
    input  logic [7:0]                    wr_dat,
    output logic [NUM_CLB*LUT_BITS-1:0]   rd_lut,
    output logic [NUM_CLB*SEL_W-1:0]      rd_sel
);

    localparam int DEPTH = NUM_CLB * FRAME_BYTES;

    logic [7:0] bank_q [DEPTH];
    logic [7:0] bank_d [DEPTH];

    // Write the addressed byte; all other bytes hold.
    always_comb begin
        bank_d = bank_q;
        for (int c = 0; c < NUM_CLB; c++) begin
            for (int b = 0; b < FRAME_BYTES; b++) begin
                if (wr_en && (int'(wr_clb) == c) && (int'(wr_byte) == b)) begin
                    bank_d[c*FRAME_BYTES + b] = wr_dat;
                end
            end
        end
    end

    // Bank storage; cleared on reset so a partial load never survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    // Parallel read-out: LUT bytes little-endian, select from the low bits of byte 4.
    always_comb begin
        rd_lut = '0;
        rd_sel = '0;
        for (int c = 0; c < NUM_CLB; c++) begin
            for (int k = 0; k < LUT_BITS/8; k++) begin
                rd_lut[c*LUT_BITS + 8*k +: 8] = bank_q[c*FRAME_BYTES + k];
            end
            rd_sel[c*SEL_W +: SEL_W] = bank_q[c*FRAME_BYTES + SEL_BYTE][SEL_W-1:0];
        end
    end

endmodule

// File: rtl/clb_cfg_ctrl.sv
// CLB configuration controller: byte stream -> shadow bank -> XOR check -> atomic commit.
// Latency: commit and done/err visible right after the checksum transfer edge.
// Backpressure: cfg_ready is registered from state only; high in LOAD/CHECK, one byte per cycle.
module clb_cfg_ctrl
    import clb_cfg_pkg::*;
#(
    parameter int NUM_CLB = 4,
    parameter int SEL_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  cfg_data,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic [NUM_CLB*LUT_BITS-1:0] lut_init,
    output logic [NUM_CLB*SEL_W-1:0]    clb_sel,
    output logic                        clb_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int                   CLB_IDX_W = clb_idx_w(NUM_CLB);
    localparam logic [CLB_IDX_W-1:0] LAST_CLB  = CLB_IDX_W'(NUM_CLB - 1);
    localparam logic [2:0]           LAST_BYTE = 3'(SEL_BYTE);

    cfg_state_e                   state_q, state_d;
    logic [2:0]                   byte_idx_q, byte_idx_d;
    logic [CLB_IDX_W-1:0]         clb_idx_q, clb_idx_d;
    logic [7:0]                   acc_q, acc_d;
    logic [NUM_CLB*LUT_BITS-1:0]  lut_q, lut_d;
    logic [NUM_CLB*SEL_W-1:0]     sel_q, sel_d;
    logic                         cfg_ready_q, cfg_ready_d;
    logic                         clb_en_q, clb_en_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic                         xfer;
    logic                         wr_en;
    logic [NUM_CLB*LUT_BITS-1:0]  shadow_lut;
    logic [NUM_CLB*SEL_W-1:0]     shadow_sel;

    assign xfer = cfg_valid && cfg_ready_q;

    clb_cfg_shadow #(
        .NUM_CLB   (NUM_CLB),
        .CLB_IDX_W (CLB_IDX_W),
        .SEL_W     (SEL_W)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_clb  (clb_idx_q),
        .wr_byte (byte_idx_q),
        .wr_dat  (cfg_data),
        .rd_lut  (shadow_lut),
        .rd_sel  (shadow_sel)
    );

    // Next state, counters, running XOR and commit decision.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        clb_idx_d  = clb_idx_q;
        acc_d      = acc_q;
        lut_d      = lut_q;
        sel_d      = sel_q;
        wr_en      = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    acc_d = acc_q ^ cfg_data;
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        if (clb_idx_q == LAST_CLB) begin
                            state_d = ST_CHECK;
                        end else begin
                            clb_idx_d = clb_idx_q + CLB_IDX_W'(1);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (cfg_data == acc_q) begin
                        // Last frame byte landed in the shadow a cycle ago, so it is complete.
                        lut_d   = shadow_lut;
                        sel_d   = shadow_sel;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            default: begin
                // IDLE, DONE, ERROR: only start matters; stray bytes are dropped.
                if (start) begin
                    state_d    = ST_LOAD;
                    byte_idx_d = '0;
                    clb_idx_d  = '0;
                    acc_d      = '0;
                end
            end
        endcase

        cfg_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        busy_d      = cfg_ready_d;
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERROR);
        clb_en_d    = (state_d == ST_DONE);
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= '0;
            clb_idx_q   <= '0;
            acc_q       <= '0;
            lut_q       <= '0;
            sel_q       <= '0;
            cfg_ready_q <= 1'b0;
            clb_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            clb_idx_q   <= clb_idx_d;
            acc_q       <= acc_d;
            lut_q       <= lut_d;
            sel_q       <= sel_d;
            cfg_ready_q <= cfg_ready_d;
            clb_en_q    <= clb_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign lut_init  = lut_q;
    assign clb_sel   = sel_q;
    assign clb_en    = clb_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/clb_cfg_ctrl.md
# clb_cfg_ctrl

Configuration controller for an array of `clb` cells; each cell is a 5-input LUT with a 2-bit mode select. It accepts a byte-wide configuration stream under a valid/ready handshake and assembles per-CLB frames in a shadow bank. It verifies a trailing XOR checksum, then commits all frames atomically to the CLB configuration outputs. It sits between the configuration port and the CLB array and gates the array's enable during reconfiguration.

## Interface
- `NUM_CLB`, 4: number of CLBs configured; legal range is 1..16.
- `LUT_BITS`, 32: LUT init width (2^5 for `data_in[4:0]`); fixed at 32.
- `SEL_W`, 2: CLB select width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin (re)configuration.
- `cfg_data`  in  8  configuration byte.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  controller accepts a byte; a transfer occurs when `cfg_valid && cfg_ready` at a rising edge.
- `lut_init`  out  NUM_CLB*32  committed LUT contents; CLB i occupies bits [32i+31:32i].
- `clb_sel`  out  NUM_CLB*2  committed select; CLB i occupies bits [2i+1:2i].
- `clb_en`  out  1  CLB array enable.
- `busy`  out  1  high in LOAD or CHECK.
- `done`  out  1  high in DONE.
- `err`  out  1  high in ERROR.

## Operation
- Frame format: 5 bytes per CLB, sent in CLB order 0..NUM_CLB-1.
  - Bytes 0..3 carry the LUT, little-endian (byte0 → lut[7:0]).
  - Byte 4 carries sel in [1:0]; bits [7:2] are ignored for the select but are included in the checksum.
- After all frames, one checksum byte follows. It equals the XOR of all 5*NUM_CLB frame bytes.
- IDLE: `cfg_ready`=0, `clb_en`=0.
  - `start` → LOAD.
  - Entering LOAD clears `byte_idx`, `clb_idx` and the running XOR.
- LOAD: `cfg_ready`=1.
  - Each transfer writes the shadow byte [clb_idx][byte_idx] and XORs the byte into the accumulator.
  - `byte_idx` wraps 4→0 and increments `clb_idx`.
  - When byte 4 of CLB NUM_CLB-1 is transferred → CHECK.
- CHECK: `cfg_ready`=1.
  - On transfer, if the byte equals the accumulator: copy the shadow bank to `lut_init`/`clb_sel` on that same edge → DONE.
  - On mismatch → ERROR, with no commit.
- DONE: `clb_en`=1. `start` → LOAD, and `clb_en` drops on that edge.
- ERROR: `clb_en`=0. `lut_init`/`clb_sel` retain the last committed configuration. `start` → LOAD.
- `start` in LOAD or CHECK is ignored; the load in progress continues.
- A `cfg_valid` with no transfer (IDLE/DONE/ERROR) is ignored; bytes are not buffered.
- Reset, at any time including mid-load:
  - state=IDLE.
  - `lut_init`, `clb_sel`, `clb_en`, `busy`, `done`, `err`, `cfg_ready` all 0.
  - Shadow bank, counters and XOR cleared.
  - A partial load is discarded.

## Timing
- All outputs are registered or decoded from the registered state only. `cfg_ready` has no combinational path from `cfg_valid`.
- `start` sampled at edge N → state LOAD and `cfg_ready`=1 after edge N.
- Checksum transfer at edge M:
  - New `lut_init`/`clb_sel` and `done`/`clb_en`=1 are visible after edge M (zero extra latency).
  - On error, `err`=1 after edge M.
- A minimum configuration takes 5*NUM_CLB+1 transfer cycles after `start`. With `cfg_valid` held high there is one byte per cycle and no bubbles.
- Committed outputs change only on a good-checksum edge or on reset. They never show a partially loaded configuration.

## Structure
- Package `clb_cfg_pkg` holds:
  - the state enum (IDLE, LOAD, CHECK, DONE, ERROR);
  - `FRAME_BYTES`=5;
  - `SEL_BYTE`=4;
  - `LUT_BITS`=32.
- `clb_idx` width is $clog2(NUM_CLB), with a minimum of 1. `byte_idx` is 3 bits.
- One sub-module, `clb_cfg_shadow`: a NUM_CLB×5-byte write-addressed shadow bank with a parallel read-out for commit. The FSM, counters, XOR and committed registers stay in `clb_cfg_ctrl`.

## Test plan
All scenarios use NUM_CLB=2.
- Reset then idle → all outputs 0; `cfg_valid`=1 with `cfg_data`=0xAA produces no transfer and `cfg_ready`=0.
- `start`, then stream 40 00 00 00 02 FF FF FF FF 01, then 43 → `done`=1 and `clb_en`=1 after the checksum edge. `lut_init`[31:0]=0x00000040, `clb_sel`[1:0]=2, `lut_init`[63:32]=0xFFFFFFFF, `clb_sel`[3:2]=1.
- Repeat the same stream with checksum 44 → `err`=1, `clb_en`=0, outputs unchanged from the previous commit.
- Stream with `cfg_valid` toggling every other cycle → same result as the first load. The byte count is exactly 11 transfers regardless of gaps.
- `start` pulsed during LOAD after byte 3 → ignored; the load completes normally.
- Assert `rst` after byte 6 → immediate IDLE with all outputs 0. A subsequent full good load succeeds.
